uart_packet_tx: RTL and testbench
=================================

// Module: uart_packet_tx
// PURPOSE
//   Multi-byte UART packet transmitter: latches a packet of up to MAX_BYTES bytes and serialises it on one line.
//   Byte 0 (i_packet[7:0]) goes first; bits within a byte go LSB first.
//   Generalises the single-byte UART TX: adds packet length, optional parity, 1/2 stop bits, inter-byte gap and abort.
//   Used by the host-side logic and benches to send command frames (e.g. 11-byte encrypt commands) to top_level.
// PARAMETERS
//   CLKS_PER_BIT   5208  clk cycles per bit (50 MHz / 9600 baud); must be >= 2
//   MAX_BYTES      11    packet buffer depth in bytes
//   PARITY_EN      0     1 = append a parity bit after the data bits
//   PARITY_ODD     0     parity sense when PARITY_EN=1: 0 even, 1 odd
//   STOP_BITS      1     stop bits per byte; only 1 or 2 are legal
//   GAP_BITS       0     idle-high bit times inserted between bytes (not after the last byte)
// PORTS
//   clk          in   1                    system clock, all logic on the rising edge
//   reset_n      in   1                    asynchronous active-low reset
//   i_start      in   1                    start request, sampled only in IDLE
//   i_packet     in   MAX_BYTES*8          packet data, byte k = i_packet[8k+7:8k]
//   i_len        in   $clog2(MAX_BYTES+1)  number of bytes to send
//   i_abort      in   1                    abort the current packet
//   o_tx_serial  out  1                    serial line, idle high
//   o_busy       out  1                    high from the accepted start until return to IDLE
//   o_byte_done  out  1                    1-cycle pulse at the end of each byte's last stop bit
//   o_pkt_done   out  1                    1-cycle pulse when the full packet completes
//   o_err        out  1                    1-cycle pulse when a start is rejected for a bad length
// BEHAVIOUR
//   - Reset (async, reset_n=0): state IDLE; o_tx_serial=1; o_busy, o_byte_done, o_pkt_done, o_err = 0; counters = 0.
//   - All outputs are registered.
//   - States: IDLE -> START -> DATA -> [PARITY] -> STOP -> (GAP -> START | START | IDLE).
//   - IDLE, i_start=1, 1 <= i_len <= MAX_BYTES:
//       latch i_packet and i_len; o_busy=1 and o_tx_serial=0 (start bit) from the next cycle.
//   - IDLE, i_start=1, i_len=0 or i_len>MAX_BYTES: o_err pulses next cycle; stay IDLE; line stays high.
//   - i_start while busy: ignored. Latched data does not change mid-packet.
//   - Each bit lasts exactly CLKS_PER_BIT cycles, counted by the bit-timer from 0 to CLKS_PER_BIT-1.
//   - DATA: 8 bits, LSB first.
//   - PARITY (PARITY_EN=1 only): bit = ^byte ^ PARITY_ODD.
//   - STOP: line high for STOP_BITS bit times. o_byte_done pulses in the final cycle of the last stop bit.
//   - After STOP:
//       more bytes and GAP_BITS>0 -> GAP, line high for GAP_BITS bit times, then START;
//       more bytes and GAP_BITS=0 -> START directly;
//       last byte -> IDLE.
//   - Last byte: o_pkt_done pulses together with its o_byte_done. o_busy falls on the following cycle,
//     and a new start is accepted that cycle.
//   - Frame length F = 1 + 8 + PARITY_EN + STOP_BITS bits.
//     Packet duration from the first start-bit cycle = (len*F + (len-1)*GAP_BITS) * CLKS_PER_BIT cycles.
//   - i_abort=1 while busy: next cycle state=IDLE, o_tx_serial=1, o_busy=0.
//     o_pkt_done and o_byte_done are not pulsed; partial frames are truncated.
//     i_abort in IDLE has no effect. If i_start and i_abort are both high in IDLE, the start is honoured.
//   - reset_n asserted mid-packet: line forced high immediately; no done pulses.
//   - Byte index and bit counters wrap only through IDLE; there is no wrap between packets.
// TESTING
//   Bench setup: CLKS_PER_BIT=4 for speed.
//   1. 1 byte 8'hA5, defaults -> line samples 0,1,0,1,0,0,1,0,1,1 per 4 clks; o_pkt_done after exactly 40 clks; o_busy then falls.
//   2. len=11, packet 88'hEFBE0001FFFFFFFFFFFF01 -> bytes 01,FF,FF,FF,FF,FF,FF,01,00,BE,EF received in order
//      by a uart_rx with the same CLKS_PER_BIT; 11 o_byte_done pulses; 1 o_pkt_done.
//   3. PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, GAP_BITS=3, 2 bytes 8'h07,8'h03:
//      parity bits 1 then 0; 2 stop bits; 12 idle clks between bytes; total (2*12+3)*4 = 108 clks.
//   4. i_len=0, then i_len=12 -> each gives one o_err pulse, o_busy stays 0, line stays 1.
//   5. Abort during DATA of byte 2 of 4 -> line high next cycle, o_busy=0, no o_pkt_done;
//      an immediate restart sends the full new packet correctly.
//   6. i_start re-pulsed mid-packet with different data, and reset_n pulsed low mid-bit ->
//      re-pulse is ignored; on reset the line goes high asynchronously and all outputs read their reset values.

Source files
------------

// File: rtl/uart_packet_tx.sv
// rtl/uart_packet_tx.sv - multi-byte UART packet transmitter with parity, stop bits, gap and abort
module uart_packet_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int MAX_BYTES    = 11,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             i_start,
  input  logic [MAX_BYTES*8-1:0]           i_packet,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   i_len,
  input  logic                             i_abort,
  output logic                             o_tx_serial,
  output logic                             o_busy,
  output logic                             o_byte_done,
  output logic                             o_pkt_done,
  output logic                             o_err
);

  localparam int LEN_W = $clog2(MAX_BYTES + 1);
  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int GAP_W = $clog2(GAP_BITS + 1) + 1;

  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  // Done pulses are registered, so they are armed one cycle before the final stop-bit cycle.
  localparam logic [TMR_W-1:0] TMR_PRE   = TMR_W'(CLKS_PER_BIT - 2);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_BYTES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;

  logic [2:0]             state;
  logic [TMR_W-1:0]       timer;
  logic [2:0]             bit_idx;
  logic [LEN_W-1:0]       byte_idx;
  logic [LEN_W-1:0]       len_q;
  logic                   stop_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [MAX_BYTES*8-1:0] pkt_q;

  logic [7:0] cur_byte;
  logic [2:0] next_bit;
  logic       last_byte;
  logic       parity_bit;
  logic       len_ok;
  logic       end_of_frame;

  assign cur_byte     = 8'(pkt_q >> {byte_idx, 3'b000});
  assign next_bit     = bit_idx + 3'd1;
  assign last_byte    = ((byte_idx + LEN_W'(1)) == len_q);
  assign parity_bit   = (^cur_byte) ^ (PARITY_ODD != 0);
  assign len_ok       = (i_len != '0) && (i_len <= LEN_MAX);
  assign end_of_frame = (state == S_STOP) && (stop_cnt == STOP_LAST) && (timer == TMR_PRE);

  // Packet sequencer: bit timer, bit/byte indices and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      len_q       <= '0;
      stop_cnt    <= 1'b0;
      gap_cnt     <= '0;
      pkt_q       <= '0;
      o_tx_serial <= 1'b1;
      o_busy      <= 1'b0;
      o_byte_done <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_byte_done <= 1'b0;
      o_pkt_done  <= 1'b0;
      o_err       <= 1'b0;
      if (state != S_IDLE && i_abort) begin
        // Abort truncates the frame and suppresses done pulses.
        state       <= S_IDLE;
        timer       <= '0;
        o_tx_serial <= 1'b1;
        o_busy      <= 1'b0;
      end else if (state == S_IDLE) begin
        if (i_start) begin
          if (len_ok) begin
            pkt_q       <= i_packet;
            len_q       <= i_len;
            byte_idx    <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            gap_cnt     <= '0;
            timer       <= '0;
            state       <= S_START;
            o_tx_serial <= 1'b0;
            o_busy      <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
        end
      end else if (timer != TMR_LAST) begin
        timer <= timer + TMR_W'(1);
        if (end_of_frame) begin
          o_byte_done <= 1'b1;
          o_pkt_done  <= last_byte;
        end
      end else begin
        timer <= '0;
        case (state)
          S_START: begin
            state       <= S_DATA;
            bit_idx     <= '0;
            o_tx_serial <= cur_byte[0];
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state       <= S_PARITY;
                o_tx_serial <= parity_bit;
              end else begin
                state       <= S_STOP;
                stop_cnt    <= 1'b0;
                o_tx_serial <= 1'b1;
              end
            end else begin
              bit_idx     <= next_bit;
              o_tx_serial <= cur_byte[next_bit];
            end
          end
          S_PARITY: begin
            state       <= S_STOP;
            stop_cnt    <= 1'b0;
            o_tx_serial <= 1'b1;
          end
          S_STOP: begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else if (last_byte) begin
              state       <= S_IDLE;
              o_tx_serial <= 1'b1;
              o_busy      <= 1'b0;
            end else begin
              byte_idx <= byte_idx + LEN_W'(1);
              if (GAP_BITS > 0) begin
                state       <= S_GAP;
                gap_cnt     <= '0;
                o_tx_serial <= 1'b1;
              end else begin
                state       <= S_START;
                o_tx_serial <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (gap_cnt != GAP_LAST) begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end else begin
              state       <= S_START;
              o_tx_serial <= 1'b0;
            end
          end
          default: begin
            state       <= S_IDLE;
            o_tx_serial <= 1'b1;
            o_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// tb/tb_uart_packet_tx.sv - self-checking bench for uart_packet_tx
module tb_uart_packet_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        reset_n;
  logic        start_a;
  logic        start_p;
  logic [87:0] i_packet;
  logic [3:0]  i_len;
  logic        i_abort;

  logic a_tx, a_busy, a_bd, a_pd, a_err;
  logic p_tx, p_busy, p_bd, p_pd, p_err;

  logic sel_p;
  logic m_tx, m_busy, m_bd, m_pd;
  assign m_tx   = sel_p ? p_tx   : a_tx;
  assign m_busy = sel_p ? p_busy : a_busy;
  assign m_bd   = sel_p ? p_bd   : a_bd;
  assign m_pd   = sel_p ? p_pd   : a_pd;

  uart_packet_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(11)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(start_a), .i_packet(i_packet),
    .i_len(i_len), .i_abort(i_abort), .o_tx_serial(a_tx), .o_busy(a_busy),
    .o_byte_done(a_bd), .o_pkt_done(a_pd), .o_err(a_err)
  );

  uart_packet_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(11), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2), .GAP_BITS(3)) dut_p (
    .clk(clk), .reset_n(reset_n), .i_start(start_p), .i_packet(i_packet),
    .i_len(i_len), .i_abort(i_abort), .o_tx_serial(p_tx), .o_busy(p_busy),
    .o_byte_done(p_bd), .o_pkt_done(p_pd), .o_err(p_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks;
  int   failures;
  logic line_q[$];
  int   bd, pd, pd_at, n;

  typedef struct {
    int          len;
    logic [87:0] pkt;
    bit          err;
    int          cycles;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_pkt(input bit use_p, input int len, input logic [87:0] pkt,
                         input int limit, input int repulse_at);
    sel_p    = use_p;
    i_packet = pkt;
    i_len    = 4'(len);
    if (use_p) start_p = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_p = 1'b0;
    line_q.delete();
    bd = 0; pd = 0; pd_at = 0; n = 0;
    while (m_busy && n < limit) begin
      n++;
      line_q.push_back(m_tx);
      if (m_bd) bd++;
      if (m_pd) begin pd++; pd_at = n; end
      if (n == repulse_at) begin
        i_packet = ~pkt;
        i_len    = 4'd1;
        if (use_p) start_p = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0;
        start_p = 1'b0;
      end
      tick();
    end
    start_a = 1'b0;
    start_p = 1'b0;
    chk("run_ended", 32'(m_busy), 0);
  endtask

  task automatic run_err(input int len);
    i_len   = 4'(len);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("err_pulse", 32'(a_err), 1);
    chk("err_busy", 32'(a_busy), 0);
    chk("err_line", 32'(a_tx), 1);
    tick();
    chk("err_clear", 32'(a_err), 0);
    chk("err_busy2", 32'(a_busy), 0);
    chk("err_line2", 32'(a_tx), 1);
  endtask

  task automatic chk_frame(input string nm, input int base, input logic [7:0] exp,
                           input bit par, input logic exp_par, input int stops);
    logic [7:0] got;
    int idx;
    got = '0;
    chk({nm, "_start"}, 32'(line_q[base + 2]), 0);
    for (int j = 0; j < 8; j++) got[j] = line_q[base + (1 + j) * CPB + 2];
    chk({nm, "_data"}, 32'(got), 32'(exp));
    idx = base + 9 * CPB;
    if (par) begin
      chk({nm, "_parity"}, 32'(line_q[idx + 2]), 32'(exp_par));
      idx += CPB;
    end
    for (int s = 0; s < stops; s++) chk({nm, "_stop"}, 32'(line_q[idx + s * CPB + 2]), 1);
  endtask

  initial begin
    logic [7:0] exp2[11];
    logic       exp1[10];
    int         zeros;
    logic [87:0] p;
    checks = 0; failures = 0;
    reset_n = 1'b0; start_a = 1'b0; start_p = 1'b0; i_abort = 1'b0;
    i_packet = '0; i_len = '0; sel_p = 1'b0;

    vecs[0] = '{1,  88'hA5, 1'b0, 40};
    vecs[1] = '{11, 88'hEFBE0001FFFFFFFFFFFF01, 1'b0, 440};
    vecs[2] = '{0,  88'h55, 1'b1, 0};
    vecs[3] = '{12, 88'h55, 1'b1, 0};
    vecs[4] = '{3,  88'hC35A80, 1'b0, 120};
    exp1 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp2 = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'hBE, 8'hEF};

    repeat (3) tick();
    chk("rst_line", 32'(a_tx), 1);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_bd", 32'(a_bd), 0);
    chk("rst_pd", 32'(a_pd), 0);
    chk("rst_err", 32'(a_err), 0);
    reset_n = 1'b1;
    tick();

    // Abort while idle does nothing.
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("idle_abort_busy", 32'(a_busy), 0);
    chk("idle_abort_line", 32'(a_tx), 1);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].err) begin
        run_err(vecs[i].len);
      end else begin
        run_pkt(1'b0, vecs[i].len, vecs[i].pkt, 2000, -1);
        chk("pkt_done_cnt", 32'(pd), 1);
        chk("pkt_done_at", 32'(pd_at), 32'(vecs[i].cycles));
        chk("byte_done_cnt", 32'(bd), 32'(vecs[i].len));
        chk("busy_cycles", 32'(line_q.size()), 32'(vecs[i].cycles));
        p = vecs[i].pkt;
        for (int b = 0; b < vecs[i].len; b++)
          chk_frame("vec_frame", b * 10 * CPB, p[8 * b +: 8], 1'b0, 1'b0, 1);
        if (i == 0)
          for (int k = 0; k < 10; k++) chk("a5_bit", 32'(line_q[k * CPB + 2]), 32'(exp1[k]));
        if (i == 1)
          for (int b = 0; b < 11; b++) chk_frame("cmd_byte", b * 10 * CPB, exp2[b], 1'b0, 1'b0, 1);
      end
    end

    // Parity, two stop bits, three gap bit times.
    run_pkt(1'b1, 2, 88'h0307, 500, -1);
    chk("par_pd_at", 32'(pd_at), 108);
    chk("par_bd", 32'(bd), 2);
    chk("par_pd", 32'(pd), 1);
    chk_frame("par_b0", 0, 8'h07, 1'b1, 1'b1, 2);
    chk_frame("par_b1", 60, 8'h03, 1'b1, 1'b0, 2);
    zeros = 0;
    for (int k = 48; k < 60; k++) if (line_q[k] !== 1'b1) zeros++;
    chk("gap_high", 32'(zeros), 0);
    sel_p = 1'b0;

    // Abort in DATA of the second of four bytes, then restart immediately.
    i_packet = 88'h33220011;
    i_len    = 4'd4;
    start_a  = 1'b1;
    tick();
    start_a = 1'b0;
    bd = 0; pd = 0;
    for (int k = 0; k < 49; k++) begin
      if (a_bd) bd++;
      if (a_pd) pd++;
      tick();
    end
    chk("abort_pre_line", 32'(a_tx), 0);
    chk("abort_pre_bd", 32'(bd), 1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    chk("abort_line", 32'(a_tx), 1);
    chk("abort_busy", 32'(a_busy), 0);
    chk("abort_pd", 32'(a_pd | pd[0]), 0);
    chk("abort_bd", 32'(a_bd), 0);
    run_pkt(1'b0, 2, 88'h6699, 500, -1);
    chk("restart_pd_at", 32'(pd_at), 80);
    chk_frame("restart_b0", 0, 8'h99, 1'b0, 1'b0, 1);
    chk_frame("restart_b1", 40, 8'h66, 1'b0, 1'b0, 1);

    // Start re-pulsed mid-packet is ignored.
    run_pkt(1'b0, 2, 88'h3C96, 500, 25);
    chk("repulse_pd_at", 32'(pd_at), 80);
    chk("repulse_bd", 32'(bd), 2);
    chk_frame("repulse_b0", 0, 8'h96, 1'b0, 1'b0, 1);
    chk_frame("repulse_b1", 40, 8'h3C, 1'b0, 1'b0, 1);
    tick();
    chk("repulse_idle", 32'(a_busy), 0);

    // Start and abort together in idle: start wins.
    i_packet = 88'h00;
    i_len    = 4'd1;
    start_a  = 1'b1;
    i_abort  = 1'b1;
    tick();
    start_a = 1'b0;
    i_abort = 1'b0;
    chk("start_abort_busy", 32'(a_busy), 1);
    chk("start_abort_line", 32'(a_tx), 0);
    n = 0;
    while (a_busy && n < 200) begin n++; tick(); end
    chk("start_abort_len", 32'(n), 40);

    // Asynchronous reset mid-bit.
    i_packet = 88'h0000;
    i_len    = 4'd2;
    start_a  = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (10) tick();
    chk("pre_rst_line", 32'(a_tx), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_line", 32'(a_tx), 1);
    chk("async_rst_busy", 32'(a_busy), 0);
    chk("async_rst_bd", 32'(a_bd), 0);
    chk("async_rst_pd", 32'(a_pd), 0);
    chk("async_rst_err", 32'(a_err), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(a_busy), 0);
    chk("post_rst_line", 32'(a_tx), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
